avr_sram_bridge: RTL and testbench

- Parametrised, single-clock bridge between the AVR control port and the external SRAM.
- Loads the SRAM address serially from the AVR, using a clock-enable divider rather than a derived clock.
- Runs timed read and write cycles with programmable wait states and optional address auto-increment.
- Sits between the CPLD top-level pins and the SRAM. Split tristate data buses; pads are resolved at top level.

---
 rtl/avr_sram_bridge_if.sv | 40 ++++
 rtl/avr_sram_bridge.sv | 182 ++++++++++++++++++
 tb/tb_avr_sram_bridge.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_sram_bridge_if.sv
// AVR control port / SRAM bus bundle for avr_sram_bridge.
// slave  : the bridge side (takes AVR requests and SRAM read data, drives strobes/address/data).
// master : the surrounding pins/environment (drives AVR requests and SRAM read data).
// Split data buses: *_data_in from pads, *_data_out plus *_data_oe towards pads.
`timescale 1ns/1ps
interface avr_sram_bridge_if #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 8
);
  logic              avr_si;
  logic              avr_sreg_en;
  logic              avr_counter;
  logic              avr_we;
  logic              avr_oe;
  logic [DATA_W-1:0] avr_data_in;
  logic [DATA_W-1:0] avr_data_out;
  logic              avr_data_oe;
  logic [DATA_W-1:0] sram_data_in;
  logic [DATA_W-1:0] sram_data_out;
  logic              sram_data_oe;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              busy;
  logic              err;
  logic [7:0]        debug;

  modport slave (
    input  avr_si, avr_sreg_en, avr_counter, avr_we, avr_oe, avr_data_in, sram_data_in,
    output avr_data_out, avr_data_oe, sram_data_out, sram_data_oe, sram_addr,
           sram_ce_n, sram_oe_n, sram_we_n, busy, err, debug
  );

  modport master (
    output avr_si, avr_sreg_en, avr_counter, avr_we, avr_oe, avr_data_in, sram_data_in,
    input  avr_data_out, avr_data_oe, sram_data_out, sram_data_oe, sram_addr,
           sram_ce_n, sram_oe_n, sram_we_n, busy, err, debug
  );
endinterface

// File: rtl/avr_sram_bridge.sv
// Single-clock bridge between the AVR control port and an external SRAM.
// Serially loads the SRAM address (clock-enable divided), then runs timed
// read/write cycles with WAIT_CYCLES-long strobes and optional auto-increment.
// Ports: avr_clk, avr_reset (synchronous, active high), bus (avr_sram_bridge_if.slave).
// debug = {state[3:0], shift_tick (one cycle delayed), busy, err, addr[0]}.
`timescale 1ns/1ps
module avr_sram_bridge #(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SHIFT_DIV   = 4,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            avr_clk,
  input  logic            avr_reset,
  avr_sram_bridge_if.slave bus
);

  localparam int unsigned DIV_W  = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SHIFT_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_SETUP = 4'd1,
    RD_WAIT  = 4'd2,
    RD_DONE  = 4'd3,
    WR_SETUP = 4'd4,
    WR_PULSE = 4'd5,
    WR_HOLD  = 4'd6
  } state_t;

  state_t state, state_d;

  logic [4:0]        sync1, sync2;
  logic              we_prev, oe_prev;
  logic              we_s, oe_s, sreg_s, cnt_s, si_s;
  logic              we_fall, oe_fall, collide, start_wr, start_rd;
  logic              shift_en, shift_tick, wait_last, in_idle;
  logic [DIV_W-1:0]  div_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data, wr_data;
  logic              ce_n_q, oe_n_q, we_n_q, busy_q, err_q, sram_oe_q, avr_oe_q, tick_q;
  logic              ce_n_d, oe_n_d, we_n_d, busy_d, sram_oe_d, avr_oe_d;

  assign {we_s, oe_s, sreg_s, cnt_s, si_s} = sync2;

  // Request decode: falling edges of the synchronised strobes, idle only
  assign in_idle  = (state == IDLE);
  assign we_fall  = we_prev & ~we_s;
  assign oe_fall  = oe_prev & ~oe_s;
  // Either edge with the other strobe already low covers the simultaneous case too
  assign collide  = (we_fall & ~oe_s) | (oe_fall & ~we_s);
  assign start_wr = in_idle & we_fall & ~collide;
  assign start_rd = in_idle & oe_fall & ~collide;

  // Shifting is only live while idle and not launching an access
  assign shift_en   = in_idle & ~sreg_s & ~start_wr & ~start_rd;
  assign shift_tick = shift_en & (div_cnt == DIV_MAX);
  assign wait_last  = (wait_cnt == WAIT_MAX);

  // Two-stage synchronisers plus previous-value flops for edge detection
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      sync1   <= '1;
      sync2   <= '1;
      we_prev <= 1'b1;
      oe_prev <= 1'b1;
    end else begin
      sync1   <= {bus.avr_we, bus.avr_oe, bus.avr_sreg_en, bus.avr_counter, bus.avr_si};
      sync2   <= sync1;
      we_prev <= we_s;
      oe_prev <= oe_s;
    end
  end

  // Next state and registered-output targets
  always_comb begin
    state_d   = state;
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    busy_d    = 1'b0;
    sram_oe_d = 1'b0;
    avr_oe_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_wr)      state_d = WR_SETUP;
        else if (start_rd) state_d = RD_SETUP;
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: if (wait_last) state_d = WR_HOLD;
      WR_HOLD:  state_d = IDLE;
      RD_SETUP: state_d = RD_WAIT;
      RD_WAIT:  if (wait_last) state_d = RD_DONE;
      RD_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    ce_n_d    = ~((state_d == WR_SETUP) | (state_d == WR_PULSE) | (state_d == WR_HOLD) |
                  (state_d == RD_SETUP) | (state_d == RD_WAIT));
    oe_n_d    = ~((state_d == RD_SETUP) | (state_d == RD_WAIT));
    we_n_d    = ~(state_d == WR_PULSE);
    sram_oe_d = (state_d == WR_SETUP) | (state_d == WR_PULSE) | (state_d == WR_HOLD);
    // Read data stays on the AVR pads until the AVR releases oe; never during a write
    avr_oe_d  = ~oe_s & ~sram_oe_d & ((state_d == RD_DONE) | avr_oe_q);
  end

  // State and output registers
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state     <= IDLE;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      sram_oe_q <= 1'b0;
      avr_oe_q  <= 1'b0;
    end else begin
      state     <= state_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      busy_q    <= busy_d;
      sram_oe_q <= sram_oe_d;
      avr_oe_q  <= avr_oe_d;
    end
  end

  // Wait-state counter restarts on every state change
  always_ff @(posedge avr_clk) begin
    if (avr_reset || (state_d != state)) wait_cnt <= '0;
    else if ((state == WR_PULSE) || (state == RD_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Shift divider, cleared whenever shifting is not live
  always_ff @(posedge avr_clk) begin
    if (avr_reset || !shift_en) div_cnt <= '0;
    else if (div_cnt == DIV_MAX) div_cnt <= '0;
    else div_cnt <= div_cnt + DIV_W'(1);
  end

  // Address register: auto-increment on access exit, otherwise serial load
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      addr <= '0;
    end else if (((state == WR_HOLD) || (state == RD_DONE)) && !cnt_s) begin
      addr <= addr + ADDR_W'(1);
    end else if (shift_tick) begin
      addr <= ADDR_W'({addr, si_s});
    end
  end

  // Data latches and sticky error
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      rd_data <= '0;
      wr_data <= '0;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      if (start_wr) wr_data <= bus.avr_data_in;
      if ((state == RD_WAIT) && wait_last) rd_data <= bus.sram_data_in;
      if (in_idle && collide) err_q <= 1'b1;
      tick_q <= shift_tick;
    end
  end

  assign bus.avr_data_out  = rd_data;
  assign bus.avr_data_oe   = avr_oe_q;
  assign bus.sram_data_out = wr_data;
  assign bus.sram_data_oe  = sram_oe_q;
  assign bus.sram_addr     = addr;
  assign bus.sram_ce_n     = ce_n_q;
  assign bus.sram_oe_n     = oe_n_q;
  assign bus.sram_we_n     = we_n_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;
  assign bus.debug         = {state, tick_q, busy_q, err_q, addr[0]};

endmodule

// File: tb/tb_avr_sram_bridge.sv
// Randomised self-checking bench for avr_sram_bridge with a transaction-level
// reference model (expected address register, expected memory image, sticky err).
`timescale 1ns/1ps
module tb_avr_sram_bridge;

  localparam int unsigned ADDR_W      = 21;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SHIFT_DIV   = 4;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam logic [31:0] MASK        = 32'((64'd1 << ADDR_W) - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avr_sram_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avr_sram_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SHIFT_DIV(SHIFT_DIV), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .avr_clk  (clk),
    .avr_reset(rst),
    .bus      (bus.slave)
  );

  // External SRAM model with a bench-side preload port
  logic [DATA_W-1:0] sram_mem [2**ADDR_W];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) sram_mem[pre_addr] <= pre_data;
    else if (!bus.sram_ce_n && !bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_data_out;
  end
  assign bus.sram_data_in = sram_mem[bus.sram_addr];

  // Reference model state
  logic [DATA_W-1:0] exp_mem [int unsigned];
  logic [31:0]       exp_addr = '0;
  logic              exp_err  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic preload(input logic [31:0] a, input logic [DATA_W-1:0] d);
    pre_addr = ADDR_W'(a);
    pre_data = d;
    pre_en   = 1'b1;
    step();
    pre_en   = 1'b0;
    exp_mem[a] = d;
  endtask

  // Serial address load, MSB first, one bit per SHIFT_DIV cycles
  task automatic load_addr(input logic [31:0] a, input bit count_ticks);
    int ticks = 0;
    bus.avr_sreg_en = 1'b0;
    for (int b = ADDR_W - 1; b >= 0; b--) begin
      bus.avr_si = a[b];
      for (int k = 0; k < int'(SHIFT_DIV); k++) begin
        step();
        ticks += int'(bus.debug[3]);
      end
    end
    bus.avr_sreg_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      ticks += int'(bus.debug[3]);
    end
    exp_addr = a & MASK;
    check_eq("load_addr", 32'(bus.sram_addr), exp_addr);
    if (count_ticks) check_eq("shift_ticks", 32'(ticks), ADDR_W);
  endtask

  task automatic do_write(input logic [DATA_W-1:0] d, input bit inc);
    int ce = 0, we = 0, bz = 0, ov = 0;
    bit seen = 0, done = 0;
    logic [31:0] a = exp_addr;
    bus.avr_data_in = d;
    bus.avr_counter = ~inc;
    bus.avr_we      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (!bus.sram_ce_n) ce++;
      if (!bus.sram_we_n) we++;
      if (bus.avr_data_oe && bus.sram_data_oe) ov++;
      if (bus.busy) begin bz++; seen = 1; end
      else if (seen) done = 1;
    end
    bus.avr_we = 1'b1;
    check_eq("wr_complete", 32'(done), 1);
    check_eq("wr_ce_cycles", 32'(ce), WAIT_CYCLES + 2);
    check_eq("wr_we_cycles", 32'(we), WAIT_CYCLES);
    check_eq("wr_busy_cycles", 32'(bz), WAIT_CYCLES + 2);
    check_eq("wr_oe_overlap", 32'(ov), 0);
    exp_mem[a] = d;
    check_eq("wr_mem", 32'(sram_mem[ADDR_W'(a)]), 32'(d));
    if (inc) exp_addr = (exp_addr + 1) & MASK;
    idle(4);
    check_eq("wr_addr_after", 32'(bus.sram_addr), exp_addr);
  endtask

  task automatic do_read(input bit inc);
    int ce = 0, oe = 0, bz = 0;
    bit seen = 0, done = 0, got_oe = 0;
    logic [DATA_W-1:0] got = '0;
    logic [31:0] a = exp_addr;
    if (!exp_mem.exists(a)) preload(a, DATA_W'($urandom));
    bus.avr_counter = ~inc;
    bus.avr_oe      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (!bus.sram_ce_n) ce++;
      if (!bus.sram_oe_n) oe++;
      if (bus.avr_data_oe && !got_oe) begin got_oe = 1; got = bus.avr_data_out; end
      if (bus.busy) begin bz++; seen = 1; end
      else if (seen) done = 1;
    end
    check_eq("rd_complete", 32'(done), 1);
    check_eq("rd_ce_cycles", 32'(ce), WAIT_CYCLES + 1);
    check_eq("rd_oe_cycles", 32'(oe), WAIT_CYCLES + 1);
    check_eq("rd_busy_cycles", 32'(bz), WAIT_CYCLES + 2);
    check_eq("rd_data_oe_seen", 32'(got_oe), 1);
    check_eq("rd_data", 32'(got), 32'(exp_mem[a]));
    idle(2);
    check_eq("rd_data_oe_held", 32'(bus.avr_data_oe), 1);
    bus.avr_oe = 1'b1;
    idle(2);
    check_eq("rd_data_oe_late", 32'(bus.avr_data_oe), 1);
    step();
    check_eq("rd_data_oe_drop", 32'(bus.avr_data_oe), 0);
    if (inc) exp_addr = (exp_addr + 1) & MASK;
    idle(2);
    check_eq("rd_addr_after", 32'(bus.sram_addr), exp_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.avr_si      = 1'b0;
    bus.avr_sreg_en = 1'b1;
    bus.avr_counter = 1'b1;
    bus.avr_we      = 1'b1;
    bus.avr_oe      = 1'b1;
    bus.avr_data_in = '0;

    // Reset state
    idle(3);
    rst = 1'b0;
    step();
    check_eq("rst_ce_n", 32'(bus.sram_ce_n), 1);
    check_eq("rst_we_n", 32'(bus.sram_we_n), 1);
    check_eq("rst_oe_n", 32'(bus.sram_oe_n), 1);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_err", 32'(bus.err), 0);
    check_eq("rst_addr", 32'(bus.sram_addr), 0);
    check_eq("rst_data_oe", 32'({bus.sram_data_oe, bus.avr_data_oe}), 0);
    idle(3);

    // Address load with tick count
    load_addr(32'h1ABCDE, 1'b1);

    // Directed write
    load_addr(32'h00010, 1'b0);
    do_write(8'hA5, 1'b0);

    // Read-back with auto-increment wrapping the top address
    load_addr(32'h1FFFFF, 1'b0);
    preload(32'h1FFFFF, 8'h3C);
    do_read(1'b1);
    check_eq("wrap_addr", 32'(bus.sram_addr), 0);

    // Collision: no access, sticky err
    begin
      int act = 0;
      bus.avr_we = 1'b0;
      bus.avr_oe = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (!bus.sram_ce_n || !bus.sram_we_n || !bus.sram_oe_n || bus.busy) act++;
      end
      bus.avr_we = 1'b1;
      bus.avr_oe = 1'b1;
      exp_err = 1'b1;
      check_eq("collide_activity", 32'(act), 0);
      check_eq("collide_err", 32'(bus.err), 32'(exp_err));
      idle(4);
    end

    // Shift request during a read access leaves the address frozen
    begin
      int moved = 0;
      bit seen = 0, done = 0;
      if (!exp_mem.exists(exp_addr)) preload(exp_addr, DATA_W'($urandom));
      bus.avr_counter = 1'b1;
      bus.avr_si      = 1'b1;
      bus.avr_oe      = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
        step();
        if (bus.busy) begin
          if (!seen) bus.avr_sreg_en = 1'b0;
          seen = 1;
          if (32'(bus.sram_addr) != exp_addr) moved++;
        end else if (seen) done = 1;
      end
      bus.avr_sreg_en = 1'b1;
      bus.avr_oe      = 1'b1;
      idle(6);
      check_eq("freeze_complete", 32'(done), 1);
      check_eq("freeze_moved", 32'(moved), 0);
      check_eq("freeze_addr", 32'(bus.sram_addr), exp_addr);
      check_eq("err_sticky", 32'(bus.err), 32'(exp_err));
    end

    // Reset in the middle of a write pulse
    begin
      bit found = 0;
      logic [31:0] a = exp_addr;
      bus.avr_data_in = 8'h5A;
      bus.avr_counter = 1'b1;
      bus.avr_we      = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        step();
        if (!bus.sram_we_n) found = 1;
      end
      rst = 1'b1;
      bus.avr_we = 1'b1;
      step();
      exp_mem[a] = 8'h5A;
      exp_addr = '0;
      exp_err  = 1'b0;
      check_eq("rstw_found", 32'(found), 1);
      check_eq("rstw_we_n", 32'(bus.sram_we_n), 1);
      check_eq("rstw_ce_n", 32'(bus.sram_ce_n), 1);
      check_eq("rstw_data_oe", 32'(bus.sram_data_oe), 0);
      check_eq("rstw_busy", 32'(bus.busy), 0);
      check_eq("rstw_addr", 32'(bus.sram_addr), exp_addr);
      check_eq("rstw_err", 32'(bus.err), 32'(exp_err));
      rst = 1'b0;
      idle(4);
    end

    // Randomised mix of loads, writes and reads
    for (int it = 0; it < 24; it++) begin
      int unsigned op = $urandom_range(0, 2);
      bit inc = 1'($urandom_range(0, 1));
      if (op == 0) load_addr($urandom & MASK, 1'b0);
      else if (op == 1) do_write(DATA_W'($urandom), inc);
      else do_read(inc);
    end
    check_eq("final_err", 32'(bus.err), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
